a51_burst_xor: RTL and testbench
================================

A51_BURST_XOR -- requirements
Module: a51_burst_xor

Interface
REQ-001 Parameter BURST_BITS, default 114: number of keystream bits consumed per burst (range 1..255).
REQ-002 Parameter FN_W, default 22: width of the frame-number counter.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  single-cycle request to begin one burst; honoured only in IDLE.
REQ-006 ks_bit  input  1  serial keystream bit (z) from the A5/1 generator.
REQ-007 ks_valid  input  1  ks_bit is valid this cycle.
REQ-008 ks_ready  output  1  block accepts ks_bit this cycle.
REQ-009 pt_data  input  8  plaintext byte.
REQ-010 pt_valid  input  1  pt_data is valid.
REQ-011 pt_ready  output  1  block accepts pt_data this cycle.
REQ-012 ct_data  output  8  ciphertext byte.
REQ-013 ct_valid  output  1  ct_data and ct_last are valid.
REQ-014 ct_ready  input  1  downstream accepts ct_data.
REQ-015 ct_last  output  1  marks the final byte of the burst.
REQ-016 frame_no  output  FN_W  current frame number, supplied to the upstream generator's frame load.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse after the final byte of a burst is accepted.

Function
REQ-019 States: IDLE, COLLECT, WAIT_PT, OUT; a handshake completes only on a cycle where valid and ready are both 1.
REQ-020 IDLE -> COLLECT on start=1; the bit counter clears, and the byte register and byte-bit counter clear.
REQ-021 COLLECT: ks_ready=1; each accepted ks_bit fills the byte register MSB-first (first bit to bit 7).
REQ-022 COLLECT -> WAIT_PT once 8 bits are accepted, or once the burst total reaches BURST_BITS, whichever comes first.
REQ-023 Partial final byte: unfilled low-order keystream positions are 0, so the matching plaintext bits pass through unchanged (BURST_BITS=114 gives 14 full bytes plus 1 byte with 2 keystream bits in [7:6]).
REQ-024 WAIT_PT: pt_ready=1; on pt handshake ct_data <= pt_data XOR keystream byte, ct_valid=1 from the next cycle, state -> OUT.
REQ-025 ct_last=1 with a byte if and only if that byte holds keystream bit number BURST_BITS-1.
REQ-026 OUT: ct_data, ct_valid and ct_last hold stable until ct_ready=1.
REQ-027 OUT on ct handshake: if not last, go to COLLECT with the byte register cleared; if last, go to IDLE, pulse done, and set frame_no <= frame_no+1 modulo 2^FN_W (2^FN_W-1 wraps to 0).
REQ-028 ks_ready, pt_ready and ct_valid are never high simultaneously, and each is 0 outside its own state.
REQ-029 start while busy is ignored, with no queuing.
REQ-030 ks_valid in any state other than COLLECT does not consume a bit.
REQ-031 Total ciphertext bytes per burst = ceil(BURST_BITS/8); bits consumed = exactly BURST_BITS.

Reset
REQ-032 reset=0 asynchronously forces IDLE and clears: ks_ready=0, pt_ready=0, ct_valid=0, ct_last=0, ct_data=0, busy=0, done=0, frame_no=0, and all internal counters.
REQ-033 reset asserted mid-burst discards the partial burst; after release the block waits in IDLE for start, and frame_no is 0.

Verification
REQ-034 Full burst, all valids held high, ct_ready=1, keystream all 1, pt=0x00: 14 bytes ct=0xFF then 1 byte ct=0xC0 with ct_last=1; done pulses once; frame_no 0->1.
REQ-035 Keystream alternating 1,0 starting with 1, pt_data=0xFE: first ct=0x54 (0xFE^0xAA); final byte ct=(0xFE^0x80)=0x7E, ct_last=1.
REQ-036 Backpressure: ct_ready=0 for 5 cycles in OUT -> ct_data, ct_valid and ct_last stable for the whole hold; ks_ready=0 and pt_ready=0 throughout.
REQ-037 ks_valid toggling every other cycle and pt_valid delayed 3 cycles -> exactly 114 bits and 15 pt bytes consumed; ciphertext matches a bitwise reference model.
REQ-038 frame_no preset near wrap via 2^22-1 bursts, or with FN_W=2 run 4 bursts -> frame_no sequence 0,1,2,3,0.
REQ-039 reset=0 asserted after 40 keystream bits -> all outputs 0 in the same cycle; start after release begins a fresh burst whose first byte is computed from new bits only.

Source files
------------

// File: rtl/a51_burst_xor.sv
// Purpose: XORs plaintext bytes with a serial A5/1 keystream, one burst of BURST_BITS keystream bits per start.
// Latency: one ciphertext byte per 8 accepted keystream bits; ct_valid rises the cycle after the plaintext handshake.
// Backpressure: valid/ready on all three streams; only one stream is ready/valid at a time, and OUT holds until ct_ready.
//
// Ports:
//   clk, reset                clock and asynchronous active-low reset
//   start                     begin one burst (ignored unless idle)
//   ks_bit/ks_valid/ks_ready  serial keystream input
//   pt_data/pt_valid/pt_ready plaintext byte input
//   ct_data/ct_valid/ct_ready/ct_last  ciphertext byte output, ct_last on the final byte
//   frame_no                  frame counter, advances after each completed burst
//   busy, done                status: not idle / one-cycle pulse at burst end
module a51_burst_xor #(
    parameter int BURST_BITS = 114,
    parameter int FN_W       = 22
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            ks_bit,
    input  logic            ks_valid,
    output logic            ks_ready,
    input  logic [7:0]      pt_data,
    input  logic            pt_valid,
    output logic            pt_ready,
    output logic [7:0]      ct_data,
    output logic            ct_valid,
    input  logic            ct_ready,
    output logic            ct_last,
    output logic [FN_W-1:0] frame_no,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WAIT_PT = 2'd2,
        S_OUT     = 2'd3
    } state_t;

    localparam logic [8:0] BURST_END = 9'(BURST_BITS);

    state_t          state_q,    state_d;
    logic [7:0]      bit_cnt_q,  bit_cnt_d;   // keystream bits consumed this burst
    logic [2:0]      byte_bit_q, byte_bit_d;  // position within the current byte
    logic [7:0]      ks_byte_q,  ks_byte_d;   // keystream byte, filled MSB-first
    logic            last_q,     last_d;      // current byte holds the final keystream bit
    logic [7:0]      ct_data_q,  ct_data_d;
    logic            ct_valid_q, ct_valid_d;
    logic            ct_last_q,  ct_last_d;
    logic [FN_W-1:0] frame_no_q, frame_no_d;
    logic            done_q,     done_d;
    logic            busy_q,     busy_d;
    logic            ks_rdy_q,   ks_rdy_d;
    logic            pt_rdy_q,   pt_rdy_d;
    logic [8:0]      bit_cnt_inc;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_bit_d  = byte_bit_q;
        ks_byte_d   = ks_byte_q;
        last_d      = last_q;
        ct_data_d   = ct_data_q;
        ct_valid_d  = ct_valid_q;
        ct_last_d   = ct_last_q;
        frame_no_d  = frame_no_q;
        done_d      = 1'b0;
        bit_cnt_inc = {1'b0, bit_cnt_q} + 9'd1;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_COLLECT;
                    bit_cnt_d  = 8'd0;
                    byte_bit_d = 3'd0;
                    ks_byte_d  = 8'd0;
                    last_d     = 1'b0;
                end
            end
            S_COLLECT: begin
                if (ks_valid) begin
                    ks_byte_d[3'd7 - byte_bit_q] = ks_bit;
                    byte_bit_d = byte_bit_q + 3'd1;
                    bit_cnt_d  = bit_cnt_inc[7:0];
                    // A byte closes when full or when the burst runs out of bits;
                    // unfilled low bits stay 0 so plaintext passes through there.
                    if (byte_bit_q == 3'd7 || bit_cnt_inc == BURST_END) begin
                        state_d = S_WAIT_PT;
                        last_d  = (bit_cnt_inc == BURST_END);
                    end
                end
            end
            S_WAIT_PT: begin
                if (pt_valid) begin
                    ct_data_d  = pt_data ^ ks_byte_q;
                    ct_valid_d = 1'b1;
                    ct_last_d  = last_q;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (ct_ready) begin
                    ct_valid_d = 1'b0;
                    ct_last_d  = 1'b0;
                    if (last_q) begin
                        state_d    = S_IDLE;
                        done_d     = 1'b1;
                        frame_no_d = frame_no_q + FN_W'(1);
                    end else begin
                        state_d    = S_COLLECT;
                        byte_bit_d = 3'd0;
                        ks_byte_d  = 8'd0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready/busy flags are registered from the next state so they line up with it.
        busy_d   = (state_d != S_IDLE);
        ks_rdy_d = (state_d == S_COLLECT);
        pt_rdy_d = (state_d == S_WAIT_PT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            byte_bit_q <= '0;
            ks_byte_q  <= '0;
            last_q     <= 1'b0;
            ct_data_q  <= '0;
            ct_valid_q <= 1'b0;
            ct_last_q  <= 1'b0;
            frame_no_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ks_rdy_q   <= 1'b0;
            pt_rdy_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_bit_q <= byte_bit_d;
            ks_byte_q  <= ks_byte_d;
            last_q     <= last_d;
            ct_data_q  <= ct_data_d;
            ct_valid_q <= ct_valid_d;
            ct_last_q  <= ct_last_d;
            frame_no_q <= frame_no_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ks_rdy_q   <= ks_rdy_d;
            pt_rdy_q   <= pt_rdy_d;
        end
    end

    assign ks_ready = ks_rdy_q;
    assign pt_ready = pt_rdy_q;
    assign ct_data  = ct_data_q;
    assign ct_valid = ct_valid_q;
    assign ct_last  = ct_last_q;
    assign frame_no = frame_no_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_a51_burst_xor.sv
// Purpose: randomized checking of a51_burst_xor against a byte-level reference model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: ct_ready stalls injected on chosen bytes; plaintext valid delayed on request.
module tb_a51_burst_xor;

    localparam int BB   = 114;
    localparam int NB   = (BB + 7) / 8;
    localparam int FN_W = 22;

    logic            clk = 1'b0;
    logic            reset;
    logic            start, ks_bit, ks_valid, ks_ready;
    logic [7:0]      pt_data;
    logic            pt_valid, pt_ready;
    logic [7:0]      ct_data;
    logic            ct_valid, ct_ready, ct_last;
    logic [FN_W-1:0] frame_no;
    logic            busy, done;

    // Small instance for frame counter wrap: 3-bit bursts, 2-bit frame number.
    logic            start2, ks_bit2, ks_valid2, ks_ready2;
    logic [7:0]      pt_data2;
    logic            pt_valid2, pt_ready2;
    logic [7:0]      ct_data2;
    logic            ct_valid2, ct_ready2, ct_last2;
    logic [1:0]      frame_no2;
    logic            busy2, done2;

    always #5 clk = ~clk;

    a51_burst_xor #(.BURST_BITS(BB), .FN_W(FN_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ks_bit(ks_bit), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_last(ct_last),
        .frame_no(frame_no), .busy(busy), .done(done)
    );

    a51_burst_xor #(.BURST_BITS(3), .FN_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .ks_bit(ks_bit2), .ks_valid(ks_valid2), .ks_ready(ks_ready2),
        .pt_data(pt_data2), .pt_valid(pt_valid2), .pt_ready(pt_ready2),
        .ct_data(ct_data2), .ct_valid(ct_valid2), .ct_ready(ct_ready2), .ct_last(ct_last2),
        .frame_no(frame_no2), .busy(busy2), .done(done2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus streams and observed results for the current burst.
    bit         ks_arr [256];
    logic [7:0] pt_arr [32];
    logic [7:0] ct_got [$];
    bit         last_got [$];
    int         bits_taken, pt_taken, done_cnt;

    // Reference: byte k pairs plaintext k with keystream bits 8k..8k+7, MSB first,
    // positions past the end of the burst contributing 0.
    function automatic logic [7:0] model_ct(input int k);
        logic [7:0] kb;
        kb = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (8 * k + i < BB) kb[7 - i] = ks_arr[8 * k + i];
        end
        return pt_arr[k] ^ kb;
    endfunction

    task automatic run_burst(input int ks_mode, input int pt_mode, input bit ks_toggle,
                             input int pt_delay, input int stall_at, input bit poke_start);
        int cyc, pt_wait, stall;
        logic [7:0] sd;
        logic sv, sl;
        logic [FN_W-1:0] fn0;

        for (int i = 0; i < 256; i++)
            ks_arr[i] = (ks_mode == 0) ? 1'b1 : (ks_mode == 1) ? bit'(i % 2 == 0) : bit'($urandom_range(0, 1));
        for (int i = 0; i < 32; i++)
            pt_arr[i] = (pt_mode == 0) ? 8'h00 : (pt_mode == 1) ? 8'hFE : 8'($urandom_range(0, 255));
        ct_got.delete();
        last_got.delete();
        bits_taken = 0; pt_taken = 0; done_cnt = 0;
        cyc = 0; pt_wait = 0; stall = 0;
        sd = 8'h00; sv = 1'b0; sl = 1'b0;
        fn0 = frame_no;

        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);

        while (ct_got.size() < NB && cyc < 3000) begin
            check("rdy_vld_exclusive", 32'((int'(ks_ready) + int'(pt_ready) + int'(ct_valid)) > 1), 0);
            ks_valid = ks_toggle ? bit'(cyc % 2) : 1'b1;
            ks_bit   = (bits_taken < 256) ? ks_arr[bits_taken] : 1'b0;
            pt_valid = (pt_wait >= pt_delay);
            pt_data  = (pt_taken < 32) ? pt_arr[pt_taken] : 8'h00;
            if (pt_ready) pt_wait++;
            if (ct_valid && ct_got.size() == stall_at && stall <= 5) begin
                if (stall == 0) begin
                    sd = ct_data; sv = ct_valid; sl = ct_last;
                end else begin
                    check("hold_ct_data", ct_data, sd);
                    check("hold_ct_valid", ct_valid, sv);
                    check("hold_ct_last", ct_last, sl);
                    check("hold_ks_ready", ks_ready, 0);
                    check("hold_pt_ready", pt_ready, 0);
                end
                ct_ready = (stall == 5);
                stall++;
            end else begin
                ct_ready = 1'b1;
            end
            start = poke_start && busy && ($urandom_range(0, 3) == 0);

            if (ks_valid && ks_ready) bits_taken++;
            if (pt_valid && pt_ready) begin
                pt_taken++;
                pt_wait = 0;
            end
            if (ct_valid && ct_ready) begin
                ct_got.push_back(ct_data);
                last_got.push_back(ct_last);
            end
            if (done) done_cnt++;
            tick();
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 3000) check("burst_timeout", 1, 0);

        // Tail: valids held high while idle must not start or feed anything.
        ks_valid = 1'b1;
        pt_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            if (ks_valid && ks_ready) bits_taken++;
            if (pt_valid && pt_ready) pt_taken++;
            if (done) done_cnt++;
            tick();
        end

        check("bits_consumed", bits_taken, BB);
        check("pt_consumed", pt_taken, NB);
        check("ct_count", ct_got.size(), NB);
        for (int k = 0; k < NB && k < ct_got.size(); k++) begin
            check($sformatf("ct_byte%0d", k), ct_got[k], model_ct(k));
            check($sformatf("ct_last%0d", k), last_got[k], (k == NB - 1));
        end
        check("done_pulses", done_cnt, 1);
        check("frame_no_inc", frame_no, fn0 + FN_W'(1));
        check("busy_idle", busy, 0);
    endtask

    task automatic run_small_burst();
        bit kb2 [3];
        logic [7:0] p, exp_ct, got_ct;
        logic got_last;
        int taken, n_ct, cyc;
        for (int i = 0; i < 3; i++) kb2[i] = bit'($urandom_range(0, 1));
        p = 8'($urandom_range(0, 255));
        exp_ct = p ^ {kb2[0], kb2[1], kb2[2], 5'b00000};
        taken = 0; n_ct = 0; cyc = 0; got_ct = 8'h00; got_last = 1'b0;
        pt_data2 = p;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        ks_valid2 = 1'b1; pt_valid2 = 1'b1; ct_ready2 = 1'b1;
        while (!done2 && cyc < 50) begin
            ks_bit2 = (taken < 3) ? kb2[taken] : 1'b0;
            if (ks_valid2 && ks_ready2) taken++;
            if (ct_valid2 && ct_ready2) begin
                got_ct = ct_data2; got_last = ct_last2; n_ct++;
            end
            tick();
            cyc++;
        end
        if (cyc >= 50) check("small_timeout", 1, 0);
        check("small_bits", taken, 3);
        check("small_ct_count", n_ct, 1);
        check("small_ct", got_ct, exp_ct);
        check("small_last", got_last, 1);
    endtask

    initial begin
        int taken;
        reset = 1'b0;
        start = 1'b0; ks_bit = 1'b0; ks_valid = 1'b0; pt_data = 8'h00; pt_valid = 1'b0; ct_ready = 1'b0;
        start2 = 1'b0; ks_bit2 = 1'b0; ks_valid2 = 1'b0; pt_data2 = 8'h00; pt_valid2 = 1'b0; ct_ready2 = 1'b0;
        #12;
        check("rst_ks_ready", ks_ready, 0);
        check("rst_pt_ready", pt_ready, 0);
        check("rst_ct_valid", ct_valid, 0);
        check("rst_ct_last", ct_last, 0);
        check("rst_ct_data", ct_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_frame_no", frame_no, 0);
        tick();
        reset = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // All-ones keystream, zero plaintext.
        run_burst(0, 0, 1'b0, 0, -1, 1'b0);
        if (ct_got.size() == NB) begin
            check("ones_first", ct_got[0], 8'hFF);
            check("ones_final", ct_got[NB - 1], 8'hC0);
        end else check("ones_size", ct_got.size(), NB);

        // Alternating keystream, plaintext 0xFE.
        run_burst(1, 1, 1'b0, 0, -1, 1'b0);
        if (ct_got.size() == NB) begin
            check("alt_first", ct_got[0], 8'h54);
            check("alt_final", ct_got[NB - 1], 8'h7E);
        end else check("alt_size", ct_got.size(), NB);

        // Random data with output stall, start poked while busy.
        run_burst(2, 2, 1'b0, 0, 3, 1'b1);
        // Toggling ks_valid, plaintext delayed 3 cycles.
        run_burst(2, 2, 1'b1, 3, -1, 1'b1);
        // Stall on the final byte.
        run_burst(2, 2, 1'b1, 1, NB - 1, 1'b1);

        // Reset in the middle of a burst after 40 keystream bits.
        start = 1'b1;
        tick();
        start = 1'b0;
        ks_valid = 1'b1; pt_valid = 1'b1; ct_ready = 1'b1;
        taken = 0;
        for (int c = 0; c < 500 && taken < 40; c++) begin
            ks_bit = bit'($urandom_range(0, 1));
            pt_data = 8'($urandom_range(0, 255));
            if (ks_valid && ks_ready) taken++;
            tick();
        end
        check("pre_reset_bits", taken, 40);
        check("pre_reset_frame", frame_no, 5);
        reset = 1'b0;
        #1;
        check("mid_rst_ks_ready", ks_ready, 0);
        check("mid_rst_pt_ready", pt_ready, 0);
        check("mid_rst_ct_valid", ct_valid, 0);
        check("mid_rst_ct_last", ct_last, 0);
        check("mid_rst_ct_data", ct_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_frame_no", frame_no, 0);
        tick();
        reset = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        check("post_rst_idle", busy, 0);
        check("post_rst_no_take", ks_ready, 0);
        run_burst(2, 2, 1'b0, 0, -1, 1'b0);

        // Frame counter wrap on the 2-bit instance.
        for (int b = 0; b < 4; b++) begin
            check($sformatf("fn2_seq%0d", b), frame_no2, b);
            run_small_burst();
        end
        check("fn2_wrap", frame_no2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
